// File: rtl/axis_trigger_sequencer.sv
// ============================================================================
// Module   : axis_trigger_sequencer
// Purpose  : Scope acquisition sequencer. It runs pre-fill, arm, trigger and
//            post-fill phases, gates the AXI-Stream samples into the ring
//            writer and latches the ring position of the trigger sample.
//            Optional macro AUTO_TRIG_EN adds an auto-trigger timeout and
//            the auto_flag output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_trigger_sequencer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16,
    parameter int TMO_WIDTH        = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        run_flag,
    input  logic [CNTR_WIDTH-1:0]       pre_data,
    input  logic [CNTR_WIDTH-1:0]       post_data,
`ifdef AUTO_TRIG_EN
    input  logic [TMO_WIDTH-1:0]        tmo_data,
    output logic                        auto_flag,
`endif
    input  logic                        trg_flag,
    output logic                        armed_flag,
    output logic                        busy_flag,
    output logic                        done_flag,
    output logic [CNTR_WIDTH-1:0]       sts_data,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNTR_WIDTH-1:0] c_CNT_ONE = CNTR_WIDTH'(1);

    if (TMO_WIDTH < 1) begin : g_tmo_width_invalid
    end

    state_t                r_state_q, w_state_d;
    logic                  r_run_prev_q;
    logic [CNTR_WIDTH-1:0] r_pos_q, w_pos_d;
    logic [CNTR_WIDTH-1:0] r_cnt_q, w_cnt_d;
    logic [CNTR_WIDTH-1:0] r_sts_q, w_sts_d;
    logic                  r_armed_q, w_armed_d;
    logic                  r_busy_q, w_busy_d;
    logic                  r_done_q, w_done_d;
    logic [CNTR_WIDTH-1:0] w_post_last;
    logic                  w_tmo_hit;
    logic                  w_trig;
`ifdef AUTO_TRIG_EN
    logic [TMO_WIDTH-1:0]  r_tmo_q, w_tmo_d;
    logic                  r_via_q, w_via_d;
    logic                  r_auto_q, w_auto_d;
`endif

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_sts_d     = r_sts_q;
        w_pos_d     = (r_busy_q && s_axis_tvalid) ? r_pos_q + c_CNT_ONE : r_pos_q;
        // post_data of 0 behaves as 1: the trigger beat is then the last beat
        w_post_last = (post_data > c_CNT_ONE) ? post_data - c_CNT_ONE : '0;
`ifdef AUTO_TRIG_EN
        w_tmo_d     = r_tmo_q;
        w_via_d     = r_via_q;
        w_auto_d    = r_auto_q;
        w_tmo_hit   = (tmo_data != '0) && (r_tmo_q == tmo_data);
`else
        w_tmo_hit   = 1'b0;
`endif
        w_trig      = s_axis_tvalid && (trg_flag || w_tmo_hit);

        case (r_state_q)
            S_IDLE: begin
                if (run_flag && !r_run_prev_q) begin
                    w_state_d = S_PRE;
                    w_pos_d   = '0;
                    w_cnt_d   = '0;
`ifdef AUTO_TRIG_EN
                    w_via_d   = 1'b0;
                    w_auto_d  = 1'b0;
`endif
                end
            end
            S_PRE: begin
                if (!run_flag) begin
                    w_state_d = S_IDLE;
                    w_cnt_d   = '0;
                end else if (pre_data == '0 ||
                             (s_axis_tvalid && r_cnt_q == pre_data - c_CNT_ONE)) begin
                    w_state_d = S_ARMED;
                    w_cnt_d   = '0;
`ifdef AUTO_TRIG_EN
                    w_tmo_d   = '0;
`endif
                end else if (s_axis_tvalid) begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
            S_ARMED: begin
                if (!run_flag) begin
                    w_state_d = S_IDLE;
                    w_cnt_d   = '0;
                end else if (w_trig) begin
                    w_sts_d = r_pos_q;
`ifdef AUTO_TRIG_EN
                    w_via_d = !trg_flag;
`endif
                    if (w_post_last == '0) begin
                        w_state_d = S_DONE;
                        w_cnt_d   = '0;
`ifdef AUTO_TRIG_EN
                        w_auto_d  = !trg_flag;
`endif
                    end else begin
                        // the trigger beat is post sample number one
                        w_state_d = S_POST;
                        w_cnt_d   = c_CNT_ONE;
                    end
                end else begin
`ifdef AUTO_TRIG_EN
                    if (!w_tmo_hit) begin
                        w_tmo_d = r_tmo_q + TMO_WIDTH'(1);
                    end
`endif
                end
            end
            S_POST: begin
                if (!run_flag) begin
                    w_state_d = S_IDLE;
                    w_cnt_d   = '0;
                end else if (s_axis_tvalid) begin
                    if (r_cnt_q == w_post_last) begin
                        w_state_d = S_DONE;
                        w_cnt_d   = '0;
`ifdef AUTO_TRIG_EN
                        w_auto_d  = r_via_q;
`endif
                    end else begin
                        w_cnt_d = r_cnt_q + c_CNT_ONE;
                    end
                end
            end
            S_DONE: begin
                if (!run_flag) begin
                    w_state_d = S_IDLE;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_cnt_d   = '0;
            end
        endcase

        w_armed_d = (w_state_d == S_ARMED);
        w_busy_d  = (w_state_d == S_PRE) || (w_state_d == S_ARMED) || (w_state_d == S_POST);
        w_done_d  = (w_state_d == S_DONE);
    end

    // The edge detector resets high so a run_flag held through reset is not a start.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q    <= S_IDLE;
            r_run_prev_q <= 1'b1;
            r_pos_q      <= '0;
            r_cnt_q      <= '0;
            r_sts_q      <= '0;
            r_armed_q    <= 1'b0;
            r_busy_q     <= 1'b0;
            r_done_q     <= 1'b0;
`ifdef AUTO_TRIG_EN
            r_tmo_q      <= '0;
            r_via_q      <= 1'b0;
            r_auto_q     <= 1'b0;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_run_prev_q <= run_flag;
            r_pos_q      <= w_pos_d;
            r_cnt_q      <= w_cnt_d;
            r_sts_q      <= w_sts_d;
            r_armed_q    <= w_armed_d;
            r_busy_q     <= w_busy_d;
            r_done_q     <= w_done_d;
`ifdef AUTO_TRIG_EN
            r_tmo_q      <= w_tmo_d;
            r_via_q      <= w_via_d;
            r_auto_q     <= w_auto_d;
`endif
        end
    end

    assign armed_flag    = r_armed_q;
    assign busy_flag     = r_busy_q;
    assign done_flag     = r_done_q;
    assign sts_data      = r_sts_q;
`ifdef AUTO_TRIG_EN
    assign auto_flag     = r_auto_q;
`endif
    assign s_axis_tready = 1'b1;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = s_axis_tvalid && r_busy_q && !areset;

endmodule

`default_nettype wire

// File: tb/tb_axis_trigger_sequencer.sv
// ============================================================================
// Module   : tb_axis_trigger_sequencer
// Purpose  : Self-checking bench for axis_trigger_sequencer with a
//            phase-level acquisition model, directed runs and random runs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_trigger_sequencer;

    localparam int DW = 16;
    localparam int CW = 4;
    localparam int TW = 8;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          run_flag = 1'b0;
    logic [CW-1:0] pre_data = '0;
    logic [CW-1:0] post_data = '0;
    logic          trg_flag = 1'b0;
    logic          armed_flag, busy_flag, done_flag;
    logic [CW-1:0] sts_data;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
`ifdef AUTO_TRIG_EN
    logic [TW-1:0] tmo_data = '0;
    logic          auto_flag;
`endif

    axis_trigger_sequencer #(
        .AXIS_TDATA_WIDTH(DW),
        .CNTR_WIDTH(CW),
        .TMO_WIDTH(TW)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .run_flag(run_flag),
        .pre_data(pre_data),
        .post_data(post_data),
`ifdef AUTO_TRIG_EN
        .tmo_data(tmo_data),
        .auto_flag(auto_flag),
`endif
        .trg_flag(trg_flag),
        .armed_flag(armed_flag),
        .busy_flag(busy_flag),
        .done_flag(done_flag),
        .sts_data(sts_data),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Acquisition model: phase, ring position, samples seen in this phase.
    localparam int PH_IDLE = 0, PH_PRE = 1, PH_ARMED = 2, PH_POST = 3, PH_DONE = 4;
    int m_ph = PH_IDLE;
    int m_pos = 0;
    int m_n = 0;
    int m_need = 1;
    int m_sts = 0;
    int m_armed_clks = 0;
    bit m_prev = 1'b1;
    bit m_via = 1'b0;
    bit m_auto = 1'b0;
    bit last_fwd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return (m_ph == PH_PRE) || (m_ph == PH_ARMED) || (m_ph == PH_POST);
    endfunction

    task automatic check_outputs();
        bit exp_fwd;
        exp_fwd = s_axis_tvalid && m_busy() && !areset;
        chk("armed_flag", armed_flag, m_ph == PH_ARMED);
        chk("busy_flag", busy_flag, m_busy());
        chk("done_flag", done_flag, m_ph == PH_DONE);
        chk("sts_data", sts_data, m_sts);
        chk("m_axis_tvalid", m_axis_tvalid, exp_fwd);
        chk("m_axis_tdata", m_axis_tdata, s_axis_tdata);
        chk("s_axis_tready", s_axis_tready, 1);
`ifdef AUTO_TRIG_EN
        chk("auto_flag", auto_flag, m_auto);
`endif
        last_fwd = m_axis_tvalid;
    endtask

    task automatic model_step();
        bit beat, hit, run;
        int nxt_pos;
        beat = s_axis_tvalid;
        run  = run_flag;
        if (areset) begin
            m_ph = PH_IDLE; m_pos = 0; m_n = 0; m_sts = 0;
            m_prev = 1'b1; m_via = 1'b0; m_auto = 1'b0; m_armed_clks = 0;
            return;
        end
        nxt_pos = (m_busy() && beat) ? (m_pos + 1) % (1 << CW) : m_pos;
        hit = 1'b0;
`ifdef AUTO_TRIG_EN
        hit = (tmo_data != 0) && (m_armed_clks >= int'(tmo_data));
`endif
        case (m_ph)
            PH_IDLE: if (run && !m_prev) begin
                m_ph = PH_PRE; nxt_pos = 0; m_n = 0; m_via = 1'b0; m_auto = 1'b0;
            end
            PH_PRE: begin
                if (!run) m_ph = PH_IDLE;
                else if (pre_data == 0) begin m_ph = PH_ARMED; m_armed_clks = 0; end
                else if (beat) begin
                    m_n++;
                    if (m_n == int'(pre_data)) begin m_ph = PH_ARMED; m_armed_clks = 0; end
                end
            end
            PH_ARMED: begin
                if (!run) m_ph = PH_IDLE;
                else if (beat && (trg_flag || hit)) begin
                    m_sts  = m_pos;
                    m_via  = !trg_flag;
                    m_need = (post_data == 0) ? 1 : int'(post_data);
                    if (m_need == 1) begin m_ph = PH_DONE; m_auto = m_via; end
                    else begin m_ph = PH_POST; m_n = 1; end
                end else m_armed_clks++;
            end
            PH_POST: begin
                if (!run) m_ph = PH_IDLE;
                else if (beat) begin
                    m_n++;
                    if (m_n == m_need) begin m_ph = PH_DONE; m_auto = m_via; end
                end
            end
            default: if (!run) m_ph = PH_IDLE;
        endcase
        m_pos  = nxt_pos;
        m_prev = run;
    endtask

    // Inputs are driven at the falling edge; one call covers one clock.
    task automatic tick();
        #1;
        check_outputs();
        model_step();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic acq(input string name, input int pre, input int post, input int gap,
                       input bit skip, input int trg_beat, input bit hold, input int ncyc,
                       input int exp_fwd, input int exp_sts, input bit exp_done);
        int b, fwd;
        b = 0; fwd = 0;
        pre_data = CW'(pre); post_data = CW'(post);
        run_flag = 1'b1; s_axis_tvalid = 1'b0; trg_flag = 1'b0;
        tick();
        for (int c = 0; c < ncyc; c++) begin
            s_axis_tvalid = !(skip && c == 0) && (c % gap == 0);
            trg_flag = s_axis_tvalid && (hold ? (b >= trg_beat) : (b == trg_beat));
            s_axis_tdata = DW'($urandom);
            tick();
            fwd += int'(last_fwd);
            b += int'(s_axis_tvalid);
        end
        s_axis_tvalid = 1'b0; trg_flag = 1'b0;
        #1;
        chk({name, "_done"}, done_flag, exp_done);
        chk({name, "_sts"}, sts_data, exp_sts);
        chk({name, "_fwd"}, fwd, exp_fwd);
        chk({name, "_model_sts"}, m_sts, exp_sts);
        run_flag = 1'b0;
        tick();
        chk({name, "_end_busy"}, busy_flag, 0);
        chk({name, "_end_done"}, done_flag, 0);
        chk({name, "_end_sts"}, sts_data, exp_sts);
        tick();
    endtask

    initial begin
        @(negedge aclk);
        areset = 1'b1;
        repeat (3) tick();
        areset = 1'b0;
        #1;
        chk("rst_armed", armed_flag, 0);
        chk("rst_busy", busy_flag, 0);
        chk("rst_done", done_flag, 0);
        chk("rst_sts", sts_data, 0);
        tick();

        acq("basic", 4, 3, 1, 0, 6, 0, 12, 9, 6, 1);
        acq("hold", 4, 3, 1, 0, 2, 1, 12, 7, 4, 1);
        acq("pre0", 0, 0, 1, 1, 0, 0, 4, 1, 0, 1);
        acq("gapped", 2, 2, 3, 0, 2, 1, 12, 4, 2, 1);
        acq("wrap", 15, 3, 1, 0, 21, 0, 26, 24, 5, 1);
        acq("abort", 2, 8, 1, 0, 3, 0, 7, 7, 3, 0);

        // run_flag held high across reset must not start a run
        areset = 1'b1; run_flag = 1'b1;
        repeat (2) tick();
        areset = 1'b0;
        repeat (4) tick();
        chk("held_run_busy", busy_flag, 0);
        run_flag = 1'b0;
        tick();

`ifdef AUTO_TRIG_EN
        tmo_data = 8'd10;
        acq("auto", 0, 1, 1, 1, 9999, 0, 14, 11, 10, 1);
        tmo_data = 8'd0;
        acq("notmo", 0, 1, 1, 1, 9999, 0, 1000, 999, 10, 0);
`endif

        for (int i = 0; i < 4000; i++) begin
            if (m_ph == PH_IDLE && !run_flag) begin
                pre_data  = ($urandom_range(0, 7) == 0) ? CW'($urandom) : CW'($urandom_range(0, 5));
                post_data = CW'($urandom_range(0, 5));
`ifdef AUTO_TRIG_EN
                tmo_data  = ($urandom_range(0, 2) == 0) ? 8'd0 : TW'($urandom_range(1, 12));
`endif
            end
            if (!run_flag) run_flag = ($urandom_range(0, 3) == 0);
            else if (m_ph == PH_DONE) run_flag = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 79) == 0) run_flag = 1'b0;
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            trg_flag      = ($urandom_range(0, 7) == 0);
            s_axis_tdata  = DW'($urandom);
            areset        = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
